wave_trace_ctrl: RTL and testbench

//  Sequences waveform display for the signal-generator scope screen: buffers one screen of samples in a

---
 rtl/wave_pkg.sv | 29 ++
 rtl/trace_buf_dp.sv | 25 ++
 rtl/wave_trace_ctrl.sv | 131 +++++++++++++
 tb/tb_wave_trace_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and types for the scope-screen waveform trace path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wave_pkg;

  localparam int SMP_W    = 8;
  localparam int N_COLS   = 1000;
  localparam int COL_W    = $clog2(N_COLS);
  localparam int PIPE_LAT = 2;

  localparam logic [10:0] X_START = 11'd140;
  localparam logic [10:0] X_END   = X_START + 11'(N_COLS - 1);
  localparam logic [10:0] Y_BASE  = 11'd464;

  // Colours used by the downstream video stage for flagged / unflagged pixels
  localparam logic [23:0] TRACE_RGB = 24'hFF0000;
  localparam logic [23:0] BG_RGB    = 24'h000000;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_FULL = 1'b1
  } wr_state_t;

  // Screen row on which a sample value is plotted
  function automatic logic [10:0] sample_row(input logic [SMP_W-1:0] s);
    return Y_BASE - 11'(s);
  endfunction

endpackage

// File: rtl/trace_buf_dp.sv
// Ping-pong column buffer: two banks of N_COLS samples, one write port, one read port.
// Latency: read data registered, 1 pixel_clk after address.
// Backpressure: none; writer and reader always address different banks.
module trace_buf_dp
  import wave_pkg::*;
(
  input  logic             pixel_clk,
  input  logic             wr_en,
  input  logic [COL_W:0]   wr_addr,
  input  logic [SMP_W-1:0] wr_data,
  input  logic [COL_W:0]   rd_addr,
  output logic [SMP_W-1:0] rd_data
);

  logic [SMP_W-1:0] mem [0:1][0:N_COLS-1];

  // Address is {bank, col}; write and registered read each cycle
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      mem[wr_addr[COL_W]][wr_addr[COL_W-1:0]] <= wr_data;
    end
    rd_data <= mem[rd_addr[COL_W]][rd_addr[COL_W-1:0]];
  end

endmodule

// File: rtl/wave_trace_ctrl.sv
// Buffers one screen of samples (ping-pong) and flags pixels lying on the joined trace.
// Latency: pixel_flag follows pixel coordinates by PIPE_LAT=2 pixel_clk cycles, no stalls.
// Backpressure: smp_ready low once the write bank is full until a frame_start swaps banks.
module wave_trace_ctrl
  import wave_pkg::*;
(
  input  logic             pixel_clk,
  input  logic             sys_rst_n,
  input  logic             frame_start,
  input  logic             freeze,
  input  logic             smp_valid,
  input  logic [SMP_W-1:0] smp_data,
  output logic             smp_ready,
  input  logic [10:0]      pixel_xpos,
  input  logic [10:0]      pixel_ypos,
  output logic             pixel_flag,
  output logic             disp_bank,
  output logic             frame_drop
);

  wr_state_t        wr_state;
  logic [COL_W-1:0] wr_ptr;
  logic             valid_seen;
  logic             smp_acc;
  logic             fill_done;

  logic             in_cols;
  logic [COL_W-1:0] rd_col;
  logic [SMP_W-1:0] rd_data;
  logic [SMP_W-1:0] prev_smp;
  logic [SMP_W-1:0] prev_eff;
  logic [SMP_W-1:0] s_max;
  logic [SMP_W-1:0] s_min;
  logic             in_cols_d1;
  logic             col0_d1;
  logic             seen_d1;
  logic [10:0]      ypos_d1;
  logic [10:0]      row_top;
  logic [10:0]      row_bot;

  assign smp_acc   = smp_valid & smp_ready;
  assign fill_done = smp_acc & (wr_ptr == COL_W'(N_COLS - 1));

  // Out-of-range columns read column 0 of the display bank; the result is masked anyway
  assign in_cols = (pixel_xpos >= X_START) && (pixel_xpos <= X_END);
  assign rd_col  = in_cols ? (pixel_xpos[COL_W-1:0] - X_START[COL_W-1:0]) : '0;

  trace_buf_dp u_buf (
    .pixel_clk (pixel_clk),
    .wr_en     (smp_acc),
    .wr_addr   ({~disp_bank, wr_ptr}),
    .wr_data   (smp_data),
    .rd_addr   ({disp_bank, rd_col}),
    .rd_data   (rd_data)
  );

  // Writer FSM: fill the hidden bank, then wait for a frame_start to swap it onto the screen
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_state   <= WR_FILL;
      wr_ptr     <= '0;
      smp_ready  <= 1'b0;
      disp_bank  <= 1'b0;
      frame_drop <= 1'b0;
      valid_seen <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      case (wr_state)
        WR_FILL: begin
          smp_ready <= 1'b1;
          if (smp_acc) begin
            if (fill_done) begin
              wr_state  <= WR_FULL;
              wr_ptr    <= '0;
              smp_ready <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
          // A frame_start landing on the completing accept is not a drop; the swap waits a frame
          if (frame_start && !fill_done) begin
            frame_drop <= 1'b1;
          end
        end
        WR_FULL: begin
          smp_ready <= 1'b0;
          if (frame_start) begin
            if (freeze) begin
              frame_drop <= 1'b1;
            end else begin
              disp_bank  <= ~disp_bank;
              valid_seen <= 1'b1;
              wr_state   <= WR_FILL;
              smp_ready  <= 1'b1;
            end
          end
        end
        default: wr_state <= WR_FILL;
      endcase
    end
  end

  // Segment bounds from current and previous column samples (col 0 has no predecessor)
  assign prev_eff = col0_d1 ? rd_data : prev_smp;
  assign s_max    = (rd_data > prev_eff) ? rd_data : prev_eff;
  assign s_min    = (rd_data > prev_eff) ? prev_eff : rd_data;
  assign row_top  = sample_row(s_max);
  assign row_bot  = sample_row(s_min);

  // Reader pipeline: stage 1 aligns coordinates with the RAM read, stage 2 compares rows
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_cols_d1 <= 1'b0;
      col0_d1    <= 1'b0;
      seen_d1    <= 1'b0;
      ypos_d1    <= '0;
      prev_smp   <= '0;
      pixel_flag <= 1'b0;
    end else begin
      in_cols_d1 <= in_cols;
      col0_d1    <= (rd_col == '0);
      seen_d1    <= valid_seen;
      ypos_d1    <= pixel_ypos;
      if (in_cols_d1) begin
        prev_smp <= rd_data;
      end
      pixel_flag <= seen_d1 & in_cols_d1 & (ypos_d1 >= row_top) & (ypos_d1 <= row_bot);
    end
  end

endmodule

// File: tb/tb_wave_trace_ctrl.sv
// Randomised bench for wave_trace_ctrl with a behavioural screen/bank model.
// Latency: checks pixel_flag two cycles after each presented coordinate.
// Backpressure: sample feeder honours smp_ready with random smp_valid gaps.
module tb_wave_trace_ctrl;

  localparam int XS = 140;
  localparam int NC = 1000;
  localparam int YB = 464;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        freeze;
  logic        smp_valid;
  logic [7:0]  smp_data;
  logic        smp_ready;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        pixel_flag;
  logic        disp_bank;
  logic        frame_drop;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: samples per bank, how many are in the write bank, shown bank
  logic [7:0] ref_mem [0:1][0:NC-1];
  int         m_cnt;
  logic       m_rdy;
  logic       m_disp;
  logic       m_drop;
  logic       m_seen;

  wave_trace_ctrl dut (
    .pixel_clk   (clk),
    .sys_rst_n   (rst_n),
    .frame_start (frame_start),
    .freeze      (freeze),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .pixel_flag  (pixel_flag),
    .disp_bank   (disp_bank),
    .frame_drop  (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: a bank is full after NC accepts; a frame_start on a full, unfrozen bank shows it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_rdy  <= 1'b0;
      m_disp <= 1'b0;
      m_drop <= 1'b0;
      m_seen <= 1'b0;
    end else begin
      automatic bit acc  = smp_valid && m_rdy;
      automatic bit full = (m_cnt == NC);
      automatic bit done = acc && (m_cnt == NC - 1);
      automatic bit swp  = frame_start && full && !freeze;
      automatic int nxt  = m_cnt + (acc ? 1 : 0);
      if (acc) ref_mem[!m_disp][m_cnt] <= smp_data;
      m_drop <= frame_start && !done && (!full || freeze);
      if (swp) begin
        m_disp <= !m_disp;
        m_seen <= 1'b1;
        nxt = 0;
      end
      m_cnt <= nxt;
      m_rdy <= (nxt < NC);
    end
  end

  // Writer-side outputs compared every cycle against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("smp_ready", smp_ready, m_rdy);
      chk("disp_bank", disp_bank, m_disp);
      chk("frame_drop", frame_drop, m_drop);
    end
  end

  // Expected flag when scanning left to right: segment from column c-1 to c on the shown bank
  function automatic bit model_flag(input int x, input int y);
    int c, cur, prv, hi, lo;
    if (!m_seen || x < XS || x > XS + NC - 1) return 1'b0;
    c   = x - XS;
    cur = ref_mem[m_disp][c];
    prv = (c == 0) ? cur : ref_mem[m_disp][c-1];
    hi  = (cur > prv) ? cur : prv;
    lo  = (cur > prv) ? prv : cur;
    return (y >= YB - hi) && (y <= YB - lo);
  endfunction

  task automatic scan(input int y, input int x_end, input bit chk_last, input bit last_exp,
                      input string tag);
    bit e[$];
    bit ex;
    int n = x_end - (XS - 2) + 1;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk) #1;
      if (i < n) begin
        pixel_xpos = 11'(XS - 2 + i);
        pixel_ypos = 11'(y);
        e.push_back(model_flag(XS - 2 + i, y));
      end else begin
        pixel_xpos = 11'd0;
      end
      @(negedge clk);
      if (i >= 2) begin
        ex = e.pop_front();
        chk(tag, pixel_flag, ex);
        if (chk_last && i == n + 1) chk({tag, "_edge"}, pixel_flag, last_exp);
      end
    end
  endtask

  // mode 0: constant 0x80, 1: ramp (col mod 256), 2: random
  task automatic feed(input int n, input int mode, input bit fs_last);
    int cnt = 0;
    int budget = 0;
    int idx;
    while (cnt < n && budget < 20 * n + 100) begin
      @(posedge clk) #1;
      frame_start = 1'b0;
      smp_valid = ($urandom_range(3) != 0);
      idx = m_cnt;
      smp_data = (mode == 0) ? 8'h80 : (mode == 1) ? idx[7:0] : 8'($urandom);
      @(negedge clk);
      if (smp_valid && smp_ready) begin
        cnt++;
        if (fs_last && cnt == n) frame_start = 1'b1;
      end
      budget++;
    end
    @(posedge clk) #1;
    smp_valid = 1'b0;
    frame_start = 1'b0;
    chk("feed_count", cnt, n);
  endtask

  task automatic pulse_fs();
    @(posedge clk) #1;
    frame_start = 1'b1;
    @(posedge clk) #1;
    frame_start = 1'b0;
  endtask

  task automatic random_scans(input int k);
    int c, y;
    for (int j = 0; j < k; j++) begin
      c = $urandom_range(NC - 1);
      y = YB - ref_mem[m_disp][c] + $urandom_range(2) - 1;
      scan(y, XS + c + $urandom_range(3), 1'b0, 1'b0, "rnd_scan");
    end
  endtask

  initial begin
    int y;
    rst_n = 1'b0;
    frame_start = 1'b0;
    freeze = 1'b0;
    smp_valid = 1'b0;
    smp_data = '0;
    pixel_xpos = '0;
    pixel_ypos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", smp_ready, 0);
    chk("rst_flag", pixel_flag, 0);
    chk("rst_disp", disp_bank, 0);
    chk("rst_drop", frame_drop, 0);
    #2 rst_n = 1'b1;
    @(posedge clk) #1;
    chk("ready_rise", smp_ready, 1);

    // Flat trace at 0x80
    feed(NC, 0, 1'b0);
    chk("t1_ready_low", smp_ready, 0);
    pulse_fs();
    chk("t1_disp", disp_bank, 1);
    chk("t1_nodrop", frame_drop, 0);
    scan(336, XS + NC - 1, 1'b1, 1'b1, "t1_row336");
    scan(336, XS + NC + 1, 1'b1, 1'b0, "t1_row336_end");
    scan(335, XS + NC + 1, 1'b0, 1'b0, "t1_row335");
    scan(337, XS + 300, 1'b0, 1'b0, "t1_row337");

    // Ramp with wrap from 255 to 0
    feed(NC, 1, 1'b0);
    pulse_fs();
    chk("t2_disp", disp_bank, 0);
    scan(209, 395, 1'b1, 1'b1, "t2_c395_r209");
    scan(210, 395, 1'b1, 1'b1, "t2_c395_r210");
    scan(211, 395, 1'b1, 1'b0, "t2_c395_r211");
    scan(208, 396, 1'b1, 1'b0, "t2_c396_r208");
    scan(209, 396, 1'b1, 1'b1, "t2_c396_r209");
    scan(300, 396, 1'b1, 1'b1, "t2_c396_r300");
    scan(464, 396, 1'b1, 1'b1, "t2_c396_r464");

    // frame_start half way through a fill
    feed(500, 2, 1'b0);
    pulse_fs();
    chk("t3_drop", frame_drop, 1);
    chk("t3_disp", disp_bank, 0);
    feed(500, 2, 1'b0);
    chk("t3_ready_low", smp_ready, 0);
    pulse_fs();
    chk("t3_swap", disp_bank, 1);
    random_scans(3);

    // Freeze holds the displayed bank
    feed(NC, 2, 1'b0);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_fs();
      chk("t4_drop", frame_drop, 1);
      chk("t4_disp", disp_bank, 1);
      chk("t4_ready", smp_ready, 0);
      repeat (4) @(posedge clk);
    end
    freeze = 1'b0;
    pulse_fs();
    chk("t4_swap", disp_bank, 0);

    // Completing accept coincident with frame_start
    feed(NC, 2, 1'b1);
    chk("t5_nodrop", frame_drop, 0);
    chk("t5_noswap", disp_bank, 0);
    pulse_fs();
    chk("t5_swap", disp_bank, 1);
    random_scans(2);

    for (int r = 0; r < 4; r++) begin
      feed(NC, 2, 1'b0);
      pulse_fs();
      random_scans(3);
    end

    // Asynchronous reset in the middle of a fill
    feed(300, 2, 1'b0);
    chk("t6_ptr", m_cnt, 300);
    @(posedge clk) #1;
    pixel_xpos = 11'(XS + 5);
    pixel_ypos = 11'(YB - ref_mem[m_disp][5]);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_flag_pre", pixel_flag, 1);
    chk("t6_disp_pre", disp_bank, 1);
    chk("t6_ready_pre", smp_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", smp_ready, 0);
    chk("t6_rst_flag", pixel_flag, 0);
    chk("t6_rst_disp", disp_bank, 0);
    chk("t6_rst_drop", frame_drop, 0);
    @(posedge clk) #3 rst_n = 1'b1;
    pixel_xpos = '0;
    feed(NC, 2, 1'b0);
    y = YB - ref_mem[0][10];
    scan(y, XS + 10, 1'b1, 1'b0, "t6_masked");
    pulse_fs();
    chk("t6_swap", disp_bank, 1);
    y = YB - ref_mem[1][10];
    scan(y, XS + 10, 1'b1, 1'b1, "t6_shown");
    random_scans(2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
